// File: rtl/nrzi_rx_decoder.sv
// nrzi_rx_decoder
//   Receive-side NRZI decoder. Recovers data bits from an NRZI line where a
//   0 bit is a line transition and a 1 bit is no transition. It hunts for a
//   sync pattern of (SYNC_LEN-1) zeros followed by a 1. It then delivers
//   payload bits, removes stuffed zeros, and flags end-of-packet and stuffing
//   violations. State only advances on cycles where bit_en is high.
//
// Optional feature (macro NRZI_RX_BYTE_EN):
//   When defined, payload bits are also assembled LSB-first into bytes and
//   presented on byte_out with a byte_valid pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   bit_en     in   strobe: in/se0 carry a valid bit sample this cycle
//   in         in   sampled NRZI line level
//   se0        in   end-of-packet line condition, sampled with bit_en
//   data_out   out  decoded payload bit, held until the next delivery
//   data_valid out  1-cycle pulse: data_out holds a new payload bit
//   sync_det   out  1-cycle pulse: sync pattern matched
//   eop_det    out  1-cycle pulse: se0 seen while receiving a packet
//   stuff_err  out  1-cycle pulse: stuffing violation, packet aborted
//   busy       out  high while receiving a packet
//   byte_out   out  last completed byte (NRZI_RX_BYTE_EN only)
//   byte_valid out  1-cycle pulse with the 8th bit of a byte (NRZI_RX_BYTE_EN only)
module nrzi_rx_decoder #(
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   SYNC_LEN   = 8,
  parameter int   STUFF_LEN  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_en,
  input  logic       in,
  input  logic       se0,
  output logic       data_out,
  output logic       data_valid,
  output logic       sync_det,
  output logic       eop_det,
  output logic       stuff_err,
  output logic       busy
`ifdef NRZI_RX_BYTE_EN
  ,
  output logic [7:0] byte_out,
  output logic       byte_valid
`endif
);

  localparam int CNT_W  = $clog2(STUFF_LEN + 1);
  localparam int FILL_W = $clog2(SYNC_LEN + 1);
  localparam logic [SYNC_LEN-1:0] SYNC_PAT  = {{(SYNC_LEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    STUFF_MAX = CNT_W'(STUFF_LEN);
  localparam logic [FILL_W-1:0]   FILL_MAX  = FILL_W'(SYNC_LEN);

  typedef enum logic [0:0] {HUNT = 1'b0, DATA = 1'b1} state_t;

  state_t                state_r, state_s;
  logic                  prev_level_r, prev_level_s;
  logic [SYNC_LEN-1:0]   hist_r, hist_s, hist_shift_s;
  // Number of real bits shifted into hist since it was last cleared
  // (saturating). A cleared history must not be mistaken for received zeros,
  // otherwise the very first decoded 1 after reset or EOP would look like sync.
  logic [FILL_W-1:0]     fill_r, fill_s, fill_inc_s;
  logic [CNT_W-1:0]      ones_cnt_r, ones_cnt_s;
  logic                  data_out_r, data_out_s;
  logic                  data_valid_r, data_valid_s;
  logic                  sync_det_r, sync_det_s;
  logic                  eop_det_r, eop_det_s;
  logic                  stuff_err_r, stuff_err_s;
  logic                  busy_r;
  logic                  dbit_s;

  assign dbit_s       = (in == prev_level_r);
  assign hist_shift_s = {hist_r[SYNC_LEN-2:0], dbit_s};
  assign fill_inc_s   = (fill_r == FILL_MAX) ? fill_r : (fill_r + FILL_W'(1));

  // Next-state and pulse decode for the hunt/data state machine
  always_comb begin
    state_s      = state_r;
    prev_level_s = prev_level_r;
    hist_s       = hist_r;
    fill_s       = fill_r;
    ones_cnt_s   = ones_cnt_r;
    data_out_s   = data_out_r;
    data_valid_s = 1'b0;
    sync_det_s   = 1'b0;
    eop_det_s    = 1'b0;
    stuff_err_s  = 1'b0;
    if (bit_en) begin
      if (se0) begin
        prev_level_s = IDLE_LEVEL;
      end else begin
        prev_level_s = in;
      end
      case (state_r)
        HUNT: begin
          if (se0) begin
            hist_s = {SYNC_LEN{1'b0}};
            fill_s = {FILL_W{1'b0}};
          end else begin
            hist_s = hist_shift_s;
            fill_s = fill_inc_s;
            if ((fill_inc_s == FILL_MAX) && (hist_shift_s == SYNC_PAT)) begin
              sync_det_s = 1'b1;
              // The sync's trailing 1 already counts toward the stuffing run.
              ones_cnt_s = CNT_W'(1);
              state_s    = DATA;
            end else begin
              state_s = HUNT;
            end
          end
        end
        DATA: begin
          if (se0) begin
            eop_det_s  = 1'b1;
            state_s    = HUNT;
            hist_s     = {SYNC_LEN{1'b0}};
            fill_s     = {FILL_W{1'b0}};
            ones_cnt_s = {CNT_W{1'b0}};
          end else if ((ones_cnt_r == STUFF_MAX) && !dbit_s) begin
            // Stuffed zero: consumed silently.
            ones_cnt_s = {CNT_W{1'b0}};
          end else if (ones_cnt_r == STUFF_MAX) begin
            stuff_err_s = 1'b1;
            state_s     = HUNT;
            hist_s      = {SYNC_LEN{1'b0}};
            fill_s      = {FILL_W{1'b0}};
            ones_cnt_s  = {CNT_W{1'b0}};
          end else begin
            data_out_s   = dbit_s;
            data_valid_s = 1'b1;
            ones_cnt_s   = dbit_s ? (ones_cnt_r + CNT_W'(1)) : {CNT_W{1'b0}};
          end
        end
        default: begin
          state_s = HUNT;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and registered-output update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= HUNT;
      prev_level_r <= IDLE_LEVEL;
      hist_r       <= {SYNC_LEN{1'b0}};
      fill_r       <= {FILL_W{1'b0}};
      ones_cnt_r   <= {CNT_W{1'b0}};
      data_out_r   <= 1'b0;
      data_valid_r <= 1'b0;
      sync_det_r   <= 1'b0;
      eop_det_r    <= 1'b0;
      stuff_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      prev_level_r <= prev_level_s;
      hist_r       <= hist_s;
      fill_r       <= fill_s;
      ones_cnt_r   <= ones_cnt_s;
      data_out_r   <= data_out_s;
      data_valid_r <= data_valid_s;
      sync_det_r   <= sync_det_s;
      eop_det_r    <= eop_det_s;
      stuff_err_r  <= stuff_err_s;
      busy_r       <= (state_s == DATA);
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign sync_det   = sync_det_r;
  assign eop_det    = eop_det_r;
  assign stuff_err  = stuff_err_r;
  assign busy       = busy_r;

`ifdef NRZI_RX_BYTE_EN
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic [7:0] byte_sr_r, byte_sr_s;
  logic [7:0] byte_out_r, byte_out_s;
  logic       byte_valid_r, byte_valid_s;

  // LSB-first byte assembly from delivered payload bits
  always_comb begin
    bit_cnt_s    = bit_cnt_r;
    byte_sr_s    = byte_sr_r;
    byte_out_s   = byte_out_r;
    byte_valid_s = 1'b0;
    if (sync_det_s || eop_det_s || stuff_err_s) begin
      bit_cnt_s = 3'd0;
    end else if (data_valid_s) begin
      byte_sr_s = {data_out_s, byte_sr_r[7:1]};
      if (bit_cnt_r == 3'd7) begin
        byte_out_s   = byte_sr_s;
        byte_valid_s = 1'b1;
        bit_cnt_s    = 3'd0;
      end else begin
        bit_cnt_s = bit_cnt_r + 3'd1;
      end
    end else begin
      bit_cnt_s = bit_cnt_r;
    end
  end

  // Byte assembler registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r    <= 3'd0;
      byte_sr_r    <= 8'd0;
      byte_out_r   <= 8'd0;
      byte_valid_r <= 1'b0;
    end else begin
      bit_cnt_r    <= bit_cnt_s;
      byte_sr_r    <= byte_sr_s;
      byte_out_r   <= byte_out_s;
      byte_valid_r <= byte_valid_s;
    end
  end

  assign byte_out   = byte_out_r;
  assign byte_valid = byte_valid_r;
`endif

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// tb_nrzi_rx_decoder
//   Self-checking bench for nrzi_rx_decoder. A queue-based packet model
//   predicts every output after each bit strobe; a compare process checks all
//   outputs on every falling edge, and a set of hand-computed literals pins
//   the key events (sync, data values, stuffing, EOP, reset).
module tb_nrzi_rx_decoder;
  localparam int   SYNC_LEN  = 8;
  localparam int   STUFF_LEN = 6;
  localparam logic IDLE      = 1'b1;

  logic clk = 1'b0;
  logic rst, bit_en, line, se0;
  logic data_out, data_valid, sync_det, eop_det, stuff_err, busy;
`ifdef NRZI_RX_BYTE_EN
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [7:0] e_byte;
  logic       e_bv;
  bit         m_bb[$];
`endif

  always #5 clk = ~clk;

  nrzi_rx_decoder #(.IDLE_LEVEL(IDLE), .SYNC_LEN(SYNC_LEN), .STUFF_LEN(STUFF_LEN)) dut (
    .clk(clk), .reset(rst), .bit_en(bit_en), .in(line), .se0(se0),
    .data_out(data_out), .data_valid(data_valid), .sync_det(sync_det),
    .eop_det(eop_det), .stuff_err(stuff_err), .busy(busy)
`ifdef NRZI_RX_BYTE_EN
    , .byte_out(byte_out), .byte_valid(byte_valid)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // expected outputs for the current cycle
  logic e_data_out, e_dv, e_sync, e_eop, e_err, e_busy;

  // model state: last line level, whether inside a packet,
  // decoded bits seen while hunting, decoded bits of the current packet
  logic m_prev;
  bit   m_in_data;
  bit   m_hunt[$];
  bit   m_pkt[$];
  logic tl;   // line level the bench is driving

  function automatic void chk1(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk8(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit is_sync();
    bit ok = (m_hunt[SYNC_LEN-1] == 1'b1);
    for (int i = 0; i < SYNC_LEN - 1; i++) if (m_hunt[i]) ok = 1'b0;
    return ok;
  endfunction

  function automatic void leave_packet();
    m_in_data = 1'b0;
    m_hunt.delete();
    m_pkt.delete();
`ifdef NRZI_RX_BYTE_EN
    m_bb.delete();
`endif
  endfunction

  // Predict outputs produced by one sampled cycle of inputs.
  task automatic model(input logic en, input logic lin, input logic lse0, input logic r);
    bit d;
    int run;
    e_dv = 1'b0; e_sync = 1'b0; e_eop = 1'b0; e_err = 1'b0;
`ifdef NRZI_RX_BYTE_EN
    e_bv = 1'b0;
`endif
    if (r) begin
      m_prev = IDLE;
      leave_packet();
      e_data_out = 1'b0;
`ifdef NRZI_RX_BYTE_EN
      e_byte = 8'h00;
`endif
    end else if (en) begin
      d = (lin == m_prev);
      if (!m_in_data) begin
        if (lse0) begin
          m_hunt.delete();
        end else begin
          m_hunt.push_back(d);
          if (m_hunt.size() > SYNC_LEN) void'(m_hunt.pop_front());
          if (m_hunt.size() == SYNC_LEN && is_sync()) begin
            e_sync = 1'b1;
            leave_packet();
            m_in_data = 1'b1;
            m_pkt.push_back(1'b1);
          end
        end
      end else begin
        run = 0;
        for (int i = m_pkt.size() - 1; i >= 0 && m_pkt[i]; i--) run++;
        if (lse0) begin
          e_eop = 1'b1;
          leave_packet();
        end else if (run == STUFF_LEN && !d) begin
          m_pkt.push_back(1'b0);
        end else if (run == STUFF_LEN) begin
          e_err = 1'b1;
          leave_packet();
        end else begin
          e_dv = 1'b1;
          e_data_out = d;
          m_pkt.push_back(d);
`ifdef NRZI_RX_BYTE_EN
          m_bb.push_back(d);
          if (m_bb.size() == 8) begin
            for (int i = 0; i < 8; i++) e_byte[i] = m_bb[i];
            e_bv = 1'b1;
            m_bb.delete();
          end
`endif
        end
      end
      m_prev = lse0 ? IDLE : lin;
    end
    e_busy = m_in_data;
  endtask

  task automatic step(input logic en, input logic lin, input logic lse0, input logic r);
    bit_en = en; line = lin; se0 = lse0; rst = r;
    @(posedge clk);
    #1;
    model(en, lin, lse0, r);
  endtask

  // send one decoded bit (0 = transition), then idle gap cycles
  task automatic send_bit(input bit b, input int gap);
    if (!b) tl = ~tl;
    step(1'b1, tl, 1'b0, 1'b0);
    for (int g = 0; g < gap; g++) step(1'b0, tl, 1'b0, 1'b0);
  endtask

  task automatic send_se0();
    step(1'b1, tl, 1'b1, 1'b0);
    tl = IDLE;
  endtask

  task automatic send_sync();
    for (int i = 0; i < SYNC_LEN - 1; i++) send_bit(1'b0, 0);
    send_bit(1'b1, 0);
  endtask

  // compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk1("data_out", data_out, e_data_out);
      chk1("data_valid", data_valid, e_dv);
      chk1("sync_det", sync_det, e_sync);
      chk1("eop_det", eop_det, e_eop);
      chk1("stuff_err", stuff_err, e_err);
      chk1("busy", busy, e_busy);
`ifdef NRZI_RX_BYTE_EN
      chk8("byte_out", byte_out, e_byte);
      chk1("byte_valid", byte_valid, e_bv);
`endif
    end
  end

  initial begin
    int r;
    rst = 1'b1; bit_en = 1'b0; line = 1'b1; se0 = 1'b0; tl = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk_on = 1'b1;
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_data_out", data_out, 1'b0);

    // idle line at 1: decodes as 1s, never a sync
    for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
    @(negedge clk);
    chk1("idle_sync", sync_det, 1'b0);
    chk1("idle_busy", busy, 1'b0);

    // line 0,1,0,1,0,1,0,0
    send_sync();
    @(negedge clk);
    chk1("sync_pulse", sync_det, 1'b1);
    chk1("sync_busy", busy, 1'b1);
    chk1("sync_no_dv", data_valid, 1'b0);

    // line 0,1,1,1 -> data 1,0,1,1, strobes 3 cycles apart
    send_bit(1'b1, 2); @(negedge clk); chk1("d0", data_out, 1'b1);
    send_bit(1'b0, 2); @(negedge clk); chk1("d1", data_out, 1'b0);
    send_bit(1'b1, 2); @(negedge clk); chk1("d2", data_out, 1'b1);
    chk1("d2_no_repeat", data_valid, 1'b0);
    send_bit(1'b1, 2); @(negedge clk); chk1("d3", data_out, 1'b1);

    // end of packet, then idle bits ignored
    send_se0();
    @(negedge clk);
    chk1("eop_pulse", eop_det, 1'b1);
    chk1("eop_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    @(negedge clk);
    chk1("post_eop_dv", data_valid, 1'b0);

    // stuffed zero after 1 (sync) + five 1s; payload 11111 1 0 1 = 8'hBF
    send_sync();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    @(negedge clk);
    chk1("stuffed_drop", data_valid, 1'b0);
    chk1("stuffed_busy", busy, 1'b1);
    send_bit(1'b1, 0);
    @(negedge clk);
    chk1("after_stuff_dv", data_valid, 1'b1);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
`ifdef NRZI_RX_BYTE_EN
    @(negedge clk);
    chk1("byte_pulse", byte_valid, 1'b1);
    chk8("byte_value", byte_out, 8'hBF);
`endif
    send_se0();

    // stuffing violation
    send_sync();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    @(negedge clk);
    chk1("stuff_err_pulse", stuff_err, 1'b1);
    chk1("stuff_err_busy", busy, 1'b0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    @(negedge clk);
    chk1("no_data_before_sync", data_valid, 1'b0);
    send_sync();
    @(negedge clk);
    chk1("resync", sync_det, 1'b1);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);

    // reset mid-packet
    step(1'b1, tl, 1'b0, 1'b1);
    tl = IDLE;
    @(negedge clk);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_data_out", data_out, 1'b0);
    chk1("midrst_dv", data_valid, 1'b0);
    step(1'b0, tl, 1'b0, 1'b0);

    // bit_en low: inputs ignored
    send_sync();
    step(1'b0, ~tl, 1'b1, 1'b0);
    step(1'b0, tl, 1'b1, 1'b0);
    @(negedge clk);
    chk1("hold_busy", busy, 1'b1);

    // mixed traffic against the model
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) send_se0();
      else if (r < 8 && !m_in_data) send_sync();
      else if (r < 20) step(1'b0, 1'($urandom), 1'($urandom), 1'b0);
      else send_bit(r < 80, 0);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule

// File: doc/nrzi_rx_decoder.md
Name: nrzi_rx_decoder

Overview:
- Receive-side counterpart of the toggle-on-0 line encoder FSM: recovers the data bit stream from an NRZI line.
- Line convention: a 0 bit is a line transition; a 1 bit is no transition.
- Hunts for a sync pattern, then delivers data bits with bit-unstuffing, end-of-packet detection and stuffing-error detection.
- Sits between the line sampler, which supplies one sample per bit via bit_en, and the packet/byte assembler.

Parameters:
- IDLE_LEVEL, 1, line level after reset and after end-of-packet; the encoder's reset output.
- SYNC_LEN, 8, sync pattern length in decoded bits: (SYNC_LEN-1) zeros then one 1. Legal 2..16.
- STUFF_LEN, 6, maximum run of decoded 1s; the bit after such a run is a stuffed 0. Legal 2..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- bit_en  in  1  strobe: in/se0 hold a valid bit sample this cycle.
- in  in  1  sampled NRZI line level.
- se0  in  1  end-of-packet line condition, sampled with bit_en.
- data_out  out  1  decoded data bit; held until next delivery.
- data_valid  out  1  1-cycle pulse: data_out is a new payload bit.
- sync_det  out  1  1-cycle pulse: sync pattern matched.
- eop_det  out  1  1-cycle pulse: se0 seen while in DATA.
- stuff_err  out  1  1-cycle pulse: stuffing violation; packet aborted.
- busy  out  1  high while in DATA state.

Behaviour:
- Reset: state=HUNT, prev_level=IDLE_LEVEL, hist=0, ones_cnt=0. All outputs 0.
- Everything advances only on cycles with bit_en=1. With bit_en=0, state and data_out hold and all pulses are 0.
- Latency: outputs are registered. Every pulse appears in the cycle after the bit_en cycle that caused it.
- Decoded bit dbit = (in == prev_level) ? 1 : 0.
- prev_level <= in on every non-se0 bit_en. On an se0 bit, prev_level <= IDLE_LEVEL.
- HUNT state:
  - Non-se0 bit: hist <= {hist[SYNC_LEN-2:0], dbit}.
  - If the new hist equals the sync pattern (newest bit 1, the older SYNC_LEN-1 bits 0): sync_det=1, ones_cnt<=1 (the sync's trailing 1 counts toward stuffing), go DATA.
  - se0 bit: hist<=0, stay in HUNT, no pulse.
- DATA state, priority order:
  1. se0 bit: eop_det=1, go HUNT, hist<=0, ones_cnt<=0.
  2. ones_cnt==STUFF_LEN and dbit=0: stuffed bit. Drop it (no data_valid), ones_cnt<=0.
  3. ones_cnt==STUFF_LEN and dbit=1: stuff_err=1, go HUNT, hist<=0, ones_cnt<=0, no data_valid.
  4. Otherwise: data_out<=dbit, data_valid=1, ones_cnt <= dbit ? ones_cnt+1 : 0.
- busy equals (state==DATA), registered. It drops in the same cycle as the eop_det or stuff_err pulse.
- At most one of sync_det, eop_det, stuff_err, data_valid is high in any cycle.
- reset during a packet has priority over bit_en: it aborts with no pulse, and all outputs are 0 the next cycle.
- ones_cnt is wide enough to hold STUFF_LEN and never wraps.

Optional Feature:
- Macro: NRZI_RX_BYTE_EN.
- Defined: adds output ports byte_out[7:0] and byte_valid (1-cycle pulse).
  - Payload bits are assembled LSB-first. byte_valid pulses in the same cycle as the data_valid of the 8th bit.
  - Bit counter clears on sync_det, eop_det, stuff_err and reset.
  - A partial byte at EOP is discarded. byte_out holds the last completed byte; reset value 0.
- Not defined: ports absent; no byte logic.

Test Plan:
- Reset, then bit_en idle with in=1 for 10 bits -> all outputs 0, busy=0, no sync_det.
- Line 0,1,0,1,0,1,0,0 on 8 strobes (decoded 0000000 then 1) -> sync_det pulse one cycle after the 8th strobe; busy=1; no data_valid.
- After sync, line 0,1,1,1 -> data_valid ×4 with data_out 1,0,1,1; strobes spaced 3 cycles apart -> pulses do not repeat.
- After sync, decoded 1,1,1,1,1 then 0 then 1 -> five valid 1s, stuffed 0 dropped (no pulse), then valid 1. With NRZI_RX_BYTE_EN, 8 payload bits give byte_valid with the LSB-first value.
- After sync, decoded 1×5 then 1 -> five valid 1s, then stuff_err pulse, busy=0. A fresh sync is then required before data resumes.
- Mid-packet se0 strobe -> eop_det pulse, busy=0, next idle bits decode as 1. Separately, reset mid-packet -> next cycle all outputs 0, state HUNT.
